uart_tx_fifo: RTL

Transmit-side byte buffer that sits directly upstream of the UART transmitter. Accepts bytes from a producer at full clock rate, stores them in a synchronous FIFO, and feeds them one at a time to the transmitter's `start`/`tx_data_in` inputs. A small drain state machine paces hand-off using the transmitter's `tx_active` and `done_tx` status. Lets the producer burst up to `DEPTH` bytes without waiting for serial line time.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered occupancy count.
// Push is rejected when full, and flush wins over both push and pop.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    // A push dropped by flush is not an overflow.
    assign overflow = push && full && !flush;
    assign rdata    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers and count
    // define validity, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter: FIFO plus a drain FSM
// that hands one byte at a time to the transmitter start/data inputs.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_active,
    input  logic                       done_tx
);

    tx_fifo_state_t    state_q;
    tx_fifo_state_t    state_d;
    logic              pop;
    logic [DATA_W-1:0] rdata;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .pop      (pop),
        .flush    (flush),
        .wdata    (wr_data),
        .rdata    (rdata),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_active && !flush) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (done_tx) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holds the popped byte steady for the whole START/WAIT frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= rdata;
        end
    end

endmodule
